// File: rtl/led_pkg.sv
// Shared types and default 48 MHz timing for the WS2812-style LED stream driver.
// Defining LED_BRIGHTNESS_EN adds the per-channel brightness scaling helper.
package led_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SEND,
        LATCH
    } led_state_t;

    typedef logic [23:0] pixel_t;

    localparam int DEF_NUM_LEDS  = 144;
    localparam int DEF_T0H_CYC   = 19;
    localparam int DEF_T1H_CYC   = 38;
    localparam int DEF_TBIT_CYC  = 60;
    localparam int DEF_LATCH_CYC = 14400;

`ifdef LED_BRIGHTNESS_EN
    // (c * (b + 1)) >> 8 per channel, so b = 255 leaves the colour untouched.
    function automatic pixel_t scale_pixel(input pixel_t p, input logic [7:0] b);
        logic [15:0] prod;
        pixel_t      res;
        res = '0;
        for (int ch = 0; ch < 3; ch++) begin
            prod = 16'(p[ch*8 +: 8]) * 16'({1'b0, b} + 9'd1);
            res[ch*8 +: 8] = prod[15:8];
        end
        return res;
    endfunction
`endif

endpackage

// File: rtl/led_bit_tx.sv
// Single-bit NRZ waveform generator: high for T0H/T1H cycles, low for the rest of TBIT.
// bit_start on the bit_done cycle chains bits with no idle gap.
module led_bit_tx
    import led_pkg::*;
#(
    parameter int T0H_CYC  = DEF_T0H_CYC,
    parameter int T1H_CYC  = DEF_T1H_CYC,
    parameter int TBIT_CYC = DEF_TBIT_CYC
) (
    input  logic clk,
    input  logic reset,
    input  logic bit_val,
    input  logic bit_start,
    output logic line,
    output logic bit_done
);

    localparam int CW = (TBIT_CYC > 1) ? $clog2(TBIT_CYC) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_active;
    logic          r_bit;
    logic          r_line;
    logic [CW-1:0] w_high;

    assign w_high   = r_bit ? CW'(T1H_CYC) : CW'(T0H_CYC);
    assign bit_done = r_active && (r_cnt == CW'(TBIT_CYC - 1));
    assign line     = r_line;

    // line is registered from the next count so the LED pin never glitches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_bit    <= 1'b0;
            r_line   <= 1'b0;
        end else if (bit_start) begin
            r_cnt    <= '0;
            r_active <= 1'b1;
            r_bit    <= bit_val;
            r_line   <= 1'b1;
        end else if (bit_done) begin
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_line   <= 1'b0;
        end else if (r_active) begin
            r_cnt  <= r_cnt + 1'b1;
            r_line <= (r_cnt + 1'b1) < w_high;
        end
    end

endmodule

// File: rtl/led_stream_driver.sv
// Streams NUM_LEDS 24-bit {G,R,B} pixels from a synchronous RAM onto a WS2812-style line.
// Optional LED_BRIGHTNESS_EN adds a brightness input that scales every channel.
module led_stream_driver
    import led_pkg::*;
#(
    parameter int NUM_LEDS  = DEF_NUM_LEDS,
    parameter int T0H_CYC   = DEF_T0H_CYC,
    parameter int T1H_CYC   = DEF_T1H_CYC,
    parameter int TBIT_CYC  = DEF_TBIT_CYC,
    parameter int LATCH_CYC = DEF_LATCH_CYC,
    localparam int AW       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [AW-1:0] pix_addr,
    output logic          pix_req,
    input  logic [23:0]   pix_data,
`ifdef LED_BRIGHTNESS_EN
    input  logic [7:0]    brightness,
`endif
    output logic          busy,
    output logic          done,
    output logic          to_light
);

    localparam int LW = $clog2(LATCH_CYC + 1);

    led_state_t    r_state;
    led_state_t    w_state_next;
    pixel_t        r_shift;
    pixel_t        r_prefetch;
    pixel_t        w_pix;
    logic [4:0]    r_bit_idx;
    logic [AW-1:0] r_pix_idx;
    logic [AW-1:0] r_addr;
    logic          r_pf_req;
    logic          r_pf_cap;
    logic [LW-1:0] r_latch_cnt;
    logic          w_bit_start;
    logic          w_bit_val;
    logic          w_bit_done;
    logic          w_line;
    logic          w_last_bit;
    logic          w_last_pix;
    logic          w_latch_end;

`ifdef LED_BRIGHTNESS_EN
    assign w_pix = scale_pixel(pix_data, brightness);
`else
    assign w_pix = pix_data;
`endif

    assign w_last_bit  = (r_bit_idx == 5'd23);
    assign w_last_pix  = (r_pix_idx == AW'(NUM_LEDS - 1));
    assign w_latch_end = (r_latch_cnt == LW'(LATCH_CYC - 1));

    assign busy     = (r_state != IDLE);
    assign pix_req  = (r_state == FETCH) | r_pf_req;
    assign pix_addr = r_addr;
    assign to_light = w_line;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_bit_start  = 1'b0;
        w_bit_val    = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = FETCH;
                end
            end
            FETCH: begin
                w_state_next = LOAD;
            end
            LOAD: begin
                w_state_next = SEND;
                w_bit_start  = 1'b1;
                w_bit_val    = w_pix[23];
            end
            SEND: begin
                if (w_bit_done) begin
                    if (!w_last_bit) begin
                        w_bit_start = 1'b1;
                        w_bit_val   = r_shift[22];
                    end else if (!w_last_pix) begin
                        w_bit_start = 1'b1;
                        w_bit_val   = r_prefetch[23];
                    end else begin
                        w_state_next = LATCH;
                    end
                end
            end
            LATCH: begin
                if (w_latch_end) begin
                    w_state_next = IDLE;
                    done         = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Next pixel is requested on the first cycle of bit 0 so it is ready long before bit 23 ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift     <= '0;
            r_prefetch  <= '0;
            r_bit_idx   <= '0;
            r_pix_idx   <= '0;
            r_addr      <= '0;
            r_pf_req    <= 1'b0;
            r_pf_cap    <= 1'b0;
            r_latch_cnt <= '0;
        end else begin
            r_pf_req <= 1'b0;
            r_pf_cap <= r_pf_req;
            if (r_pf_cap) begin
                r_prefetch <= w_pix;
            end
            case (r_state)
                IDLE: begin
                    r_latch_cnt <= '0;
                    if (start) begin
                        r_addr    <= '0;
                        r_pix_idx <= '0;
                        r_bit_idx <= '0;
                    end
                end
                LOAD: begin
                    r_shift   <= w_pix;
                    r_bit_idx <= '0;
                    r_pix_idx <= '0;
                    if (NUM_LEDS > 1) begin
                        r_pf_req <= 1'b1;
                        r_addr   <= r_addr + 1'b1;
                    end
                end
                SEND: begin
                    if (w_bit_done) begin
                        if (!w_last_bit) begin
                            r_shift   <= r_shift << 1;
                            r_bit_idx <= r_bit_idx + 5'd1;
                        end else if (!w_last_pix) begin
                            r_shift   <= r_prefetch;
                            r_bit_idx <= '0;
                            r_pix_idx <= r_pix_idx + 1'b1;
                            if (int'(r_pix_idx) + 2 < NUM_LEDS) begin
                                r_pf_req <= 1'b1;
                                r_addr   <= r_addr + 1'b1;
                            end
                        end
                    end
                end
                LATCH: begin
                    r_latch_cnt <= w_latch_end ? '0 : r_latch_cnt + 1'b1;
                end
                default: begin
                    r_latch_cnt <= '0;
                end
            endcase
        end
    end

    led_bit_tx #(
        .T0H_CYC  (T0H_CYC),
        .T1H_CYC  (T1H_CYC),
        .TBIT_CYC (TBIT_CYC)
    ) u_bit_tx (
        .clk       (clk),
        .reset     (reset),
        .bit_val   (w_bit_val),
        .bit_start (w_bit_start),
        .line      (w_line),
        .bit_done  (w_bit_done)
    );

endmodule

// File: tb/tb_led_stream_driver.sv
// Self-checking bench for led_stream_driver: frame-position model checked every cycle,
// plus decoded-pixel, timing and reset-abort checks against hand-computed values.
module tb_led_stream_driver;

    localparam int N        = 3;
    localparam int T0H      = 19;
    localparam int T1H      = 38;
    localparam int TBIT     = 60;
    localparam int LATCH    = 200;
    localparam int PIX_LEN  = 24 * TBIT;
    localparam int SEND_LEN = N * PIX_LEN;
    localparam int BUSY_LEN = 2 + SEND_LEN + LATCH;
    localparam int AW       = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] pix_addr;
    logic          pix_req;
    logic [23:0]   pix_data = '0;
    logic          busy;
    logic          done;
    logic          to_light;
`ifdef LED_BRIGHTNESS_EN
    logic [7:0]    brightness = 8'd255;
`endif

    logic [23:0] mem [0:N-1];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    led_stream_driver #(
        .NUM_LEDS  (N),
        .T0H_CYC   (T0H),
        .T1H_CYC   (T1H),
        .TBIT_CYC  (TBIT),
        .LATCH_CYC (LATCH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .pix_addr (pix_addr),
        .pix_req  (pix_req),
        .pix_data (pix_data),
`ifdef LED_BRIGHTNESS_EN
        .brightness (brightness),
`endif
        .busy     (busy),
        .done     (done),
        .to_light (to_light)
    );

    // Synchronous single-port RAM: data valid the cycle after the request.
    always @(posedge clk) begin
        if (pix_req) pix_data <= (int'(pix_addr) < N) ? mem[pix_addr] : 24'hDEAD00;
    end

    task automatic check1(input string nm, input logic got, input logic want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%b want=%b at t=%0t", nm, got, want, $time);
        end
    endtask

    task automatic checkv(input string nm, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%0h want=%0h at t=%0t", nm, got, want, $time);
        end
    endtask

    // ---------------- behavioural model: position k within the frame ----------------
    int m_k = -1;
    always @(posedge clk or posedge reset) begin
        if (reset) m_k = -1;
        else if (m_k < 0) begin
            if (start) m_k = 0;
        end else if (m_k == BUSY_LEN - 1) m_k = -1;
        else m_k = m_k + 1;
    end

    function automatic logic [23:0] tx_pixel(input logic [23:0] p);
`ifdef LED_BRIGHTNESS_EN
        logic [23:0] r;
        for (int c = 0; c < 3; c++) r[c*8 +: 8] = 8'((int'(p[c*8 +: 8]) * (int'(brightness) + 1)) / 256);
        return r;
`else
        return p;
`endif
    endfunction

    function automatic logic exp_line(input int k);
        int j, b, ph;
        logic [23:0] px;
        if (k < 2 || k >= 2 + SEND_LEN) return 1'b0;
        j  = k - 2;
        b  = j / TBIT;
        ph = j % TBIT;
        px = tx_pixel(mem[b / 24]);
        return ph < (px[23 - (b % 24)] ? T1H : T0H);
    endfunction

    always @(negedge clk) begin
        logic          e_req;
        logic [AW-1:0] e_addr;
        if (!reset) begin
            check1("busy", busy, m_k >= 0);
            check1("done", done, m_k == BUSY_LEN - 1);
            check1("to_light", to_light, exp_line(m_k));
            e_req  = 1'b0;
            e_addr = '0;
            if (m_k == 0) e_req = 1'b1;
            else if (m_k >= 2 && m_k < 2 + SEND_LEN && (m_k - 2) % PIX_LEN == 0
                     && (m_k - 2) / PIX_LEN < N - 1) begin
                e_req  = 1'b1;
                e_addr = AW'((m_k - 2) / PIX_LEN + 1);
            end
            check1("pix_req", pix_req, e_req);
            if (e_req) checkv("pix_addr", 32'(pix_addr), 32'(e_addr));
        end
    end

    // ---------------- line decoder and frame statistics ----------------
    int   cyc = 0;
    always @(posedge clk) cyc++;

    logic prev_line = 1'b0, prev_busy = 1'b0;
    int   hi_len = 0, last_rise = -1, bad_width = 0, bad_period = 0;
    int   done_cnt = 0, req_cnt = 0, busy_len = 0, last_busy_len = 0;
    int   busy_rise_cyc = 0, first_hi_cyc = -1, idle_gap = 0, last_idle_gap = 0, frames = 0;
    logic bits_q[$];
    int   req_addrs[$];

    always @(negedge clk) begin
        if (reset) begin
            prev_line = 1'b0;
            prev_busy = 1'b0;
            hi_len    = 0;
        end else begin
            if (busy && !prev_busy) begin
                frames++;
                busy_len      = 0;
                busy_rise_cyc = cyc;
                first_hi_cyc  = -1;
                last_rise     = -1;
                last_idle_gap = idle_gap;
            end
            if (!busy && prev_busy) last_busy_len = busy_len;
            if (busy) begin
                busy_len++;
                idle_gap = 0;
            end else idle_gap++;
            if (to_light && !prev_line) begin
                if (first_hi_cyc < 0) first_hi_cyc = cyc;
                if (last_rise >= 0 && cyc - last_rise != TBIT) bad_period++;
                last_rise = cyc;
                hi_len    = 0;
            end
            if (to_light) hi_len++;
            if (!to_light && prev_line) begin
                if (hi_len == T1H) bits_q.push_back(1'b1);
                else if (hi_len == T0H) bits_q.push_back(1'b0);
                else bad_width++;
            end
            if (done) done_cnt++;
            if (pix_req) begin
                req_cnt++;
                req_addrs.push_back(int'(pix_addr));
            end
            prev_line = to_light;
            prev_busy = busy;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic clear_stats();
        bits_q.delete();
        req_addrs.delete();
        bad_width  = 0;
        bad_period = 0;
        done_cnt   = 0;
        req_cnt    = 0;
        frames     = 0;
    endtask

    task automatic wait_done(input string nm);
        int d0 = done_cnt;
        int i  = 0;
        while (done_cnt == d0 && i < BUSY_LEN + 50) begin
            tick();
            i++;
        end
        if (done_cnt == d0) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout got=no_done want=done within %0d cycles", nm, BUSY_LEN + 50);
        end
        tick();
        tick();
    endtask

    task automatic pulse_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    logic [23:0] exp_words [6];

    task automatic check_words(input string nm, input int nw);
        logic [23:0] w;
        checkv({nm, "_bit_count"}, 32'(bits_q.size()), 32'(nw * 24));
        for (int i = 0; i < nw; i++) begin
            w = '0;
            for (int b = 0; b < 24; b++) w = {w[22:0], bits_q[i*24 + b]};
            checkv($sformatf("%s_word%0d", nm, i), 32'(w), 32'(exp_words[i]));
        end
        checkv({nm, "_bad_width"}, 32'(bad_width), 32'd0);
        checkv({nm, "_bad_period"}, 32'(bad_period), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mem[0] = 24'h00CEFF; mem[1] = 24'hFF0000; mem[2] = 24'hAAAAAA;

        // Reset state
        repeat (3) tick();
        check1("rst_to_light", to_light, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_pix_req", pix_req, 1'b0);
        checkv("rst_pix_addr", 32'(pix_addr), 32'd0);
        reset = 1'b0;
        repeat (3) tick();

        // Frame A: single start pulse
        clear_stats();
        pulse_start();
        wait_done("frameA");
        exp_words[0] = 24'h00CEFF; exp_words[1] = 24'hFF0000; exp_words[2] = 24'hAAAAAA;
        check_words("frameA", 3);
        checkv("frameA_req_cnt", 32'(req_cnt), 32'd3);
        for (int i = 0; i < 3; i++) checkv($sformatf("frameA_req_addr%0d", i), 32'(req_addrs[i]), 32'(i));
        checkv("frameA_busy_len", 32'(last_busy_len), 32'd4522);
        checkv("frameA_done_cnt", 32'(done_cnt), 32'd1);
        checkv("frameA_first_hi", 32'(first_hi_cyc - busy_rise_cyc), 32'd2);
        check1("frameA_idle_busy", busy, 1'b0);

        // Frame B: start held high across a whole frame and into the next
        mem[0] = 24'h123456; mem[1] = 24'h0F0F0F; mem[2] = 24'h800001;
        clear_stats();
        tick();
        start = 1'b1;
        wait_done("frameB1");
        for (int i = 0; i < 10 && frames < 2; i++) tick();
        checkv("frameB_second_start", 32'(frames), 32'd2);
        checkv("frameB_idle_gap", 32'(last_idle_gap), 32'd1);
        start = 1'b0;
        wait_done("frameB2");
        exp_words[0] = 24'h123456; exp_words[1] = 24'h0F0F0F; exp_words[2] = 24'h800001;
        exp_words[3] = 24'h123456; exp_words[4] = 24'h0F0F0F; exp_words[5] = 24'h800001;
        check_words("frameB", 6);
        checkv("frameB_frames", 32'(frames), 32'd2);
        checkv("frameB_req_cnt", 32'(req_cnt), 32'd6);

        // Frame C: reset at pixel 1, bit 10, phase 5 (line is high there)
        clear_stats();
        pulse_start();
        repeat (2 + PIX_LEN + 10 * TBIT + 5 - 1) tick();
        check1("abort_pre_line", to_light, 1'b1);
        reset = 1'b1;
        #1;
        check1("abort_line", to_light, 1'b0);
        check1("abort_busy", busy, 1'b0);
        check1("abort_req", pix_req, 1'b0);
        check1("abort_done", done, 1'b0);
        tick();
        reset = 1'b0;
        repeat (LATCH + 100) tick();
        checkv("abort_no_done", 32'(done_cnt), 32'd0);

        // Frame D: restart after abort begins at pixel 0
        mem[0] = 24'hFFFFFF; mem[1] = 24'h000000; mem[2] = 24'h0A0B0C;
        clear_stats();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check1("restart_req", pix_req, 1'b1);
        checkv("restart_addr", 32'(pix_addr), 32'd0);
        wait_done("frameD");
        exp_words[0] = 24'hFFFFFF; exp_words[1] = 24'h000000; exp_words[2] = 24'h0A0B0C;
        check_words("frameD", 3);
        checkv("frameD_busy_len", 32'(last_busy_len), 32'd4522);

`ifdef LED_BRIGHTNESS_EN
        // Frame E: brightness 127 halves each channel
        mem[0] = 24'hFF80FF; mem[1] = 24'hFF80FF; mem[2] = 24'h000100;
        brightness = 8'd127;
        clear_stats();
        pulse_start();
        wait_done("frameE");
        exp_words[0] = 24'h7F407F; exp_words[1] = 24'h7F407F; exp_words[2] = 24'h000000;
        check_words("frameE", 3);
        brightness = 8'd255;
        clear_stats();
        pulse_start();
        wait_done("frameF");
        exp_words[0] = 24'hFF80FF; exp_words[1] = 24'hFF80FF; exp_words[2] = 24'h000100;
        check_words("frameF", 3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
